// File: rtl/led_shift_driver_if.sv
// Serial LED chain bundle: parallel pattern in, 74HC595-style sclk/sdata/latch out
// plus frame status.
interface led_shift_driver_if #(
  parameter int unsigned WIDTH = 16
);
  logic [WIDTH-1:0] led_in;
  logic             sclk;
  logic             sdata;
  logic             latch;
  logic             busy;
  logic             done;

  modport master (
    input  led_in,
    output sclk,
    output sdata,
    output latch,
    output busy,
    output done
  );

  modport slave (
    output led_in,
    input  sclk,
    input  sdata,
    input  latch,
    input  busy,
    input  done
  );
endinterface

// File: rtl/led_shift_driver.sv
// Serialises a WIDTH-bit LED pattern MSB first into an external latching shift
// register chain; a frame is sent after reset and whenever the pattern changes.
module led_shift_driver #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned CLK_DIV = 4
) (
  input logic               clk,
  input logic               rst,
  led_shift_driver_if.master drv
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_MSB  = BIT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SHIFT_LO = 2'd1,
    SHIFT_HI = 2'd2,
    LATCH    = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [BIT_W-1:0] bit_idx_q, bit_idx_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic [WIDTH-1:0] last_q, last_d;
  logic             init_q, init_d;
  logic             sclk_q, sclk_d;
  logic             sdata_q, sdata_d;
  logic             latch_q, latch_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             div_end;

  // State and output registers; reset aborts any frame and forces a resend
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      div_q     <= '0;
      bit_idx_q <= '0;
      shadow_q  <= '0;
      last_q    <= '0;
      init_q    <= 1'b1;
      sclk_q    <= 1'b0;
      sdata_q   <= 1'b0;
      latch_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      bit_idx_q <= bit_idx_d;
      shadow_q  <= shadow_d;
      last_q    <= last_d;
      init_q    <= init_d;
      sclk_q    <= sclk_d;
      sdata_q   <= sdata_d;
      latch_q   <= latch_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign div_end = (div_q == DIV_LAST);

  // Next-state and next-output logic
  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    bit_idx_d = bit_idx_q;
    shadow_d  = shadow_q;
    last_d    = last_q;
    init_d    = init_q;
    sclk_d    = sclk_q;
    sdata_d   = sdata_q;
    latch_d   = latch_q;
    busy_d    = busy_q;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        sclk_d  = 1'b0;
        sdata_d = 1'b0;
        latch_d = 1'b0;
        busy_d  = 1'b0;
        if ((drv.led_in != last_q) || init_q) begin
          shadow_d  = drv.led_in;
          last_d    = drv.led_in;
          init_d    = 1'b0;
          sdata_d   = drv.led_in[WIDTH-1];
          busy_d    = 1'b1;
          div_d     = '0;
          bit_idx_d = BIT_MSB;
          state_d   = SHIFT_LO;
        end
      end
      SHIFT_LO: begin
        if (div_end) begin
          div_d   = '0;
          sclk_d  = 1'b1;
          state_d = SHIFT_HI;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      SHIFT_HI: begin
        if (div_end) begin
          div_d  = '0;
          sclk_d = 1'b0;
          // Data only moves on the falling sclk edge so the chain sees stable setup
          if (bit_idx_q != '0) begin
            bit_idx_d = bit_idx_q - BIT_W'(1);
            sdata_d   = shadow_q[bit_idx_q - BIT_W'(1)];
            state_d   = SHIFT_LO;
          end else begin
            sdata_d = 1'b0;
            latch_d = 1'b1;
            state_d = LATCH;
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      LATCH: begin
        if (div_end) begin
          div_d   = '0;
          latch_d = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign drv.sclk  = sclk_q;
  assign drv.sdata = sdata_q;
  assign drv.latch = latch_q;
  assign drv.busy  = busy_q;
  assign drv.done  = done_q;

endmodule

// File: tb/tb_led_shift_driver.sv
// Scoreboard bench: a frame-level timing model predicts which patterns get sent;
// a monitor rebuilds the external 74HC595 chain and checks each latched frame.
module tb_led_shift_driver;

  localparam int unsigned W = 16;
  localparam int D0 = 4;
  localparam int D1 = 1;
  localparam int L0 = 2 * D0 * 16 + D0;
  localparam int L1 = 2 * D1 * 16 + D1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  led_shift_driver_if #(.WIDTH(W)) if0 ();
  led_shift_driver_if #(.WIDTH(W)) if1 ();

  led_shift_driver #(.WIDTH(W), .CLK_DIV(D0)) u0 (.clk(clk), .rst(rst), .drv(if0));
  led_shift_driver #(.WIDTH(W), .CLK_DIV(D1)) u1 (.clk(clk), .rst(rst), .drv(if1));

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, got, exp);
  endtask

  // Reference model: a frame occupies L busy cycles plus one done cycle, and
  // the pattern seen at the first free edge is what gets sent.
  logic [15:0] exp0[$];
  logic [15:0] exp1[$];
  int          m_left[2] = '{0, 0};
  logic [15:0] m_last[2] = '{16'h0, 16'h0};
  logic        m_init[2] = '{1'b1, 1'b1};

  task automatic model_step(input int k, input logic [15:0] led);
    int len;
    len = (k == 0) ? L0 : L1;
    if (m_left[k] != 0) m_left[k]--;
    if (m_left[k] == 0 && (led != m_last[k] || m_init[k])) begin
      if (k == 0) exp0.push_back(led);
      else exp1.push_back(led);
      m_last[k] = led;
      m_init[k] = 1'b0;
      m_left[k] = len + 1;
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        m_left[k] = 0;
        m_last[k] = 16'h0;
        m_init[k] = 1'b1;
      end
      exp0.delete();
      exp1.delete();
    end else begin
      model_step(0, if0.led_in);
      model_step(1, if1.led_in);
    end
  end

  // Monitor: emulates the external chain and checks frame timing
  logic        p_sclk[2], p_sdata[2], p_latch[2], p_busy[2], p_done[2];
  logic [15:0] sr[2], par[2];
  int          bits[2], busy_cnt[2], latch_cnt[2], cyc[2], last_rise[2];
  int          idle_viol[2] = '{0, 0};
  int          frames[2]    = '{0, 0};
  logic        bad[2];

  task automatic mon_clear(input int k);
    p_sclk[k] = 1'b0; p_sdata[k] = 1'b0; p_latch[k] = 1'b0;
    p_busy[k] = 1'b0; p_done[k] = 1'b0;
    sr[k] = 16'h0; par[k] = 16'h0;
    bits[k] = 0; busy_cnt[k] = 0; latch_cnt[k] = 0; last_rise[k] = 0;
    bad[k] = 1'b0;
  endtask

  task automatic mon_step(input int k, input logic sc, input logic sd, input logic la,
                          input logic bu, input logic dn);
    int          d;
    int          len;
    int          qs;
    logic [15:0] e;
    d   = (k == 0) ? D0 : D1;
    len = (k == 0) ? L0 : L1;
    cyc[k]++;
    if (bu) busy_cnt[k]++;
    if (la) latch_cnt[k]++;
    if (sc && !p_sclk[k]) begin
      sr[k] = {sr[k][14:0], sd};
      bits[k]++;
      if (bits[k] > 1 && (cyc[k] - last_rise[k]) != 2 * d) bad[k] = 1'b1;
      last_rise[k] = cyc[k];
    end
    if (la && !p_latch[k]) begin
      if ((cyc[k] - last_rise[k]) != d) bad[k] = 1'b1;
      par[k] = sr[k];
    end
    if (sd != p_sdata[k] && !(!sc && p_sclk[k]) && !(bu && !p_busy[k])) bad[k] = 1'b1;
    if (!bu && (sc || la || sd)) idle_viol[k]++;
    if (dn) begin
      frames[k]++;
      check($sformatf("done_single_busy_low_%0d", k), {30'h0, p_done[k], bu}, 32'h0);
      check($sformatf("busy_len_%0d", k), busy_cnt[k], len);
      check($sformatf("latch_len_%0d", k), latch_cnt[k], d);
      check($sformatf("bit_count_%0d", k), bits[k], 16);
      check($sformatf("sclk_sdata_timing_%0d", k), {31'h0, bad[k]}, 32'h0);
      qs = (k == 0) ? exp0.size() : exp1.size();
      check($sformatf("frame_expected_%0d", k), qs, 1);
      if (qs > 0) begin
        e = (k == 0) ? exp0.pop_front() : exp1.pop_front();
        check($sformatf("latched_pattern_%0d", k), par[k], e);
      end
      bits[k] = 0; busy_cnt[k] = 0; latch_cnt[k] = 0; bad[k] = 1'b0;
    end
    p_sclk[k] = sc; p_sdata[k] = sd; p_latch[k] = la; p_busy[k] = bu; p_done[k] = dn;
  endtask

  always @(negedge clk) begin
    if (rst) begin
      mon_clear(0);
      mon_clear(1);
    end else begin
      mon_step(0, if0.sclk, if0.sdata, if0.latch, if0.busy, if0.done);
      mon_step(1, if1.sclk, if1.sdata, if1.latch, if1.busy, if1.done);
    end
  end

  task automatic wait_busy0(input int max_cyc);
    for (int i = 0; i < max_cyc; i++) begin
      @(posedge clk);
      #1;
      if (if0.busy) return;
    end
    check("busy_rise_timeout", 32'h0, 32'h1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int f;
    if0.led_in = 16'h0000;
    if1.led_in = 16'hFFFF;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_outputs_0", {27'h0, if0.sclk, if0.sdata, if0.latch, if0.busy, if0.done}, 32'h0);
    check("reset_outputs_1", {27'h0, if1.sclk, if1.sdata, if1.latch, if1.busy, if1.done}, 32'h0);
    rst = 1'b0;

    // Mandatory post-reset frame starts on the first edge
    @(posedge clk);
    #1;
    check("first_busy_0", {31'h0, if0.busy}, 32'h1);
    check("first_sdata_0", {31'h0, if0.sdata}, 32'h0);
    check("first_sclk_0", {31'h0, if0.sclk}, 32'h0);
    check("first_sdata_1", {31'h0, if1.sdata}, 32'h1);
    repeat (1200) @(negedge clk);
    check("init_frames_0", frames[0], 1);
    check("init_frames_1", frames[1], 1);

    @(negedge clk);
    if0.led_in = 16'h003F;
    repeat (300) @(negedge clk);
    check("frames_after_3f", frames[0], 2);

    // Changes during a frame: only the value present in idle is sent
    @(negedge clk);
    if0.led_in = 16'h0001;
    wait_busy0(50);
    repeat (20) @(negedge clk);
    if0.led_in = 16'h0003;
    repeat (30) @(negedge clk);
    if0.led_in = 16'h0007;
    repeat (400) @(negedge clk);
    check("frames_after_drop", frames[0], 4);

    // Flasher-style fill sequence, then random patterns with random holds
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      if0.led_in = 16'((32'd1 << i) - 32'd1);
      if1.led_in = 16'($urandom);
      repeat (200) @(negedge clk);
    end
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if0.led_in = 16'($urandom);
      if1.led_in = 16'($urandom);
      repeat ($urandom_range(5, 300)) @(negedge clk);
    end
    repeat (500) @(negedge clk);

    // Reset in the high phase of the eighth bit aborts asynchronously
    if0.led_in = 16'h0100;
    wait_busy0(50);
    repeat (61) @(posedge clk);
    #2;
    check("pre_abort_sclk", {31'h0, if0.sclk}, 32'h1);
    check("pre_abort_sdata", {31'h0, if0.sdata}, 32'h1);
    f = frames[0];
    rst = 1'b1;
    #1;
    check("abort_outputs", {28'h0, if0.sclk, if0.sdata, if0.latch, if0.busy}, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (400) @(negedge clk);
    check("resend_after_abort", frames[0], f + 1);

    check("queue_drained_0", exp0.size(), 0);
    check("queue_drained_1", exp1.size(), 0);
    check("idle_quiet_0", idle_viol[0], 0);
    check("idle_quiet_1", idle_viol[1], 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
